// File: rtl/bip_control_unit_if.sv
// Opcode-in / datapath-control-out bundle of the BIP control unit.
// The master side feeds opcode, flags and handshakes; the slave is the unit.
interface bip_control_unit_if #(
  parameter int OPCODE_W = 5,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] OpCode;
  logic                Zero;
  logic                Start;
  logic                ReportAck;
  logic                WrPC;
  logic                PcLoad;
  logic [1:0]          SelA;
  logic                SelB;
  logic                WrAcc;
  logic [2:0]          AluOp;
  logic                WrRam;
  logic                RdRam;
  logic                Halted;
  logic                ReportReq;
  logic                Illegal;
  logic [CNT_W-1:0]    CycleCount;

  modport master (
    output OpCode, Zero, Start, ReportAck,
    input  WrPC, PcLoad, SelA, SelB, WrAcc, AluOp,
    input  WrRam, RdRam, Halted, ReportReq, Illegal, CycleCount
  );

  modport slave (
    input  OpCode, Zero, Start, ReportAck,
    output WrPC, PcLoad, SelA, SelB, WrAcc, AluOp,
    output WrRam, RdRam, Halted, ReportReq, Illegal, CycleCount
  );
endinterface

// File: rtl/bip_control_unit.sv
// BIP accumulator control unit: opcode decode gated by an IDLE/RUN/HALT
// sequencer, halt-report handshake, illegal trap and cycle counter.
module bip_control_unit #(
  parameter int OPCODE_W     = 5,
  parameter int CNT_W        = 16,
  parameter bit EXT_EN       = 1'b1,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input logic               clk,
  input logic               reset,
  bip_control_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic             rep_q, rep_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] op;
  logic       hi_zero;
  logic       ill_op;
  logic       run;

  logic       wr_pc, pc_load, sel_b, wr_acc;
  logic       wr_ram, rd_ram;
  logic [1:0] sel_a;
  logic [2:0] alu;

  assign op      = bus.OpCode[4:0];
  assign hi_zero = (bus.OpCode >> 5) == '0;
  assign ill_op  = !hi_zero || (op > 5'd19)
                || (!EXT_EN && (op > 5'd7));
  assign run     = (state_q == RUN);

  always_comb begin
    wr_pc   = 1'b0;
    pc_load = 1'b0;
    sel_a   = 2'd0;
    sel_b   = 1'b0;
    wr_acc  = 1'b0;
    alu     = 3'd0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;
    if (run) begin
      wr_pc = 1'b1;
      if (ill_op) begin
        wr_pc = !ILLEGAL_HALT;
      end else begin
        unique case (1'b1)
          op == 5'd0: wr_pc = 1'b0;
          op == 5'd1: wr_ram = 1'b1;
          op == 5'd2: begin
            rd_ram = 1'b1;
            wr_acc = 1'b1;
          end
          op == 5'd3: begin
            wr_acc = 1'b1;
            sel_a  = 2'd1;
          end
          // register/immediate pairs: bit 0 selects the immediate form
          op inside {[5'd4:5'd13]}: begin
            wr_acc = 1'b1;
            sel_a  = 2'd2;
            sel_b  = op[0];
            rd_ram = !op[0];
            if (op[3:1] == 3'd2)      alu = 3'd1;
            else if (op[3:1] == 3'd3) alu = 3'd0;
            else                      alu = op[3:1] - 3'd2;
          end
          op inside {5'd14, 5'd15}: begin
            wr_acc = 1'b1;
            sel_a  = 2'd2;
            sel_b  = 1'b1;
            alu    = op[0] ? 3'd6 : 3'd5;
          end
          op == 5'd16: pc_load = bus.Zero;
          op == 5'd17: pc_load = !bus.Zero;
          op == 5'd18: pc_load = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    rep_d    = rep_q;
    ill_d    = ill_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = RUN;
          cnt_d   = '0;
          ill_d   = 1'b0;
        end
      end
      RUN: begin
        if (wr_pc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (ill_op) ill_d = 1'b1;
        // in RUN a cleared WrPC means HLT or an illegal trap
        if (!wr_pc) begin
          state_d  = HALT;
          halted_d = 1'b1;
          rep_d    = 1'b1;
        end
      end
      HALT: begin
        if (bus.ReportAck) begin
          state_d  = IDLE;
          halted_d = 1'b0;
          rep_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
      rep_q    <= 1'b0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      rep_q    <= rep_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.WrPC       = wr_pc;
  assign bus.PcLoad     = pc_load;
  assign bus.SelA       = sel_a;
  assign bus.SelB       = sel_b;
  assign bus.WrAcc      = wr_acc;
  assign bus.AluOp      = alu;
  assign bus.WrRam      = wr_ram;
  assign bus.RdRam      = rd_ram;
  assign bus.Halted     = halted_q;
  assign bus.ReportReq  = rep_q;
  assign bus.Illegal    = ill_q;
  assign bus.CycleCount = cnt_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: default build plus a build with
// EXT_EN=0, ILLEGAL_HALT=0, CNT_W=3, both against a table-driven model.
module tb_bip_control_unit;

  typedef logic [10:0] ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] a_op = '0, b_op = '0;
  logic a_zero = 0, a_start = 0, a_ack = 0;
  logic b_zero = 0, b_start = 0, b_ack = 0;

  bip_control_unit_if #(.OPCODE_W(5), .CNT_W(16)) ifa ();
  bip_control_unit_if #(.OPCODE_W(5), .CNT_W(3))  ifb ();

  assign ifa.OpCode = a_op;
  assign ifa.Zero = a_zero;
  assign ifa.Start = a_start;
  assign ifa.ReportAck = a_ack;
  assign ifb.OpCode = b_op;
  assign ifb.Zero = b_zero;
  assign ifb.Start = b_start;
  assign ifb.ReportAck = b_ack;

  bip_control_unit #(
    .OPCODE_W(5), .CNT_W(16), .EXT_EN(1'b1), .ILLEGAL_HALT(1'b1)
  ) dut_a (.clk(clk), .reset(rst_n), .bus(ifa));

  bip_control_unit #(
    .OPCODE_W(5), .CNT_W(3), .EXT_EN(1'b0), .ILLEGAL_HALT(1'b0)
  ) dut_b (.clk(clk), .reset(rst_n), .bus(ifb));

  ctl_t ctl_a, ctl_b;
  logic [18:0] regs_a;
  logic [5:0] regs_b;
  assign ctl_a = {ifa.WrPC, ifa.PcLoad, ifa.SelA, ifa.SelB,
                  ifa.WrAcc, ifa.AluOp, ifa.WrRam, ifa.RdRam};
  assign ctl_b = {ifb.WrPC, ifb.PcLoad, ifb.SelA, ifb.SelB,
                  ifb.WrAcc, ifb.AluOp, ifb.WrRam, ifb.RdRam};
  assign regs_a = {ifa.Halted, ifa.ReportReq, ifa.Illegal, ifa.CycleCount};
  assign regs_b = {ifb.Halted, ifb.ReportReq, ifb.Illegal, ifb.CycleCount};

  int n_cmp = 0;
  int n_bad = 0;

  // model: per-mnemonic control table plus abstract machine state
  ctl_t tbl[20];
  bit m_run[2], m_halt[2], m_halted[2], m_rep[2], m_ill[2];
  int m_cnt[2];
  bit p_ext[2] = '{1'b1, 1'b0};
  bit p_ih[2] = '{1'b1, 1'b0};
  int p_max[2] = '{65535, 7};

  function automatic ctl_t mk(bit w, bit p, bit [1:0] sa, bit sb,
                              bit wa, bit [2:0] al, bit wr, bit rd);
    return {w, p, sa, sb, wa, al, wr, rd};
  endfunction

  function automatic bit is_ill(int d, int op);
    return (op > 19) || (!p_ext[d] && op > 7);
  endfunction

  function automatic ctl_t exp_ctl(int d, int op, bit z);
    ctl_t c;
    if (!m_run[d]) return '0;
    if (is_ill(d, op)) return p_ih[d] ? tbl[0] : tbl[19];
    c = tbl[op];
    if (op == 16) c[9] = z;
    else if (op == 17) c[9] = !z;
    else if (op == 18) c[9] = 1'b1;
    return c;
  endfunction

  function automatic logic [18:0] exp_ra();
    return {m_halted[0], m_rep[0], m_ill[0], 16'(m_cnt[0])};
  endfunction

  function automatic logic [5:0] exp_rb();
    return {m_halted[1], m_rep[1], m_ill[1], 3'(m_cnt[1])};
  endfunction

  task automatic m_step(int d, int op, bit z, bit st, bit ak);
    ctl_t c;
    c = exp_ctl(d, op, z);
    if (!m_run[d] && !m_halt[d]) begin
      if (st) begin
        m_run[d] = 1; m_cnt[d] = 0; m_ill[d] = 0;
      end
    end else if (m_run[d]) begin
      if (c[10] && m_cnt[d] < p_max[d]) m_cnt[d]++;
      if (is_ill(d, op)) m_ill[d] = 1;
      if (!c[10]) begin
        m_run[d] = 0; m_halt[d] = 1; m_halted[d] = 1; m_rep[d] = 1;
      end
    end else if (ak) begin
      m_halt[d] = 0; m_halted[d] = 0; m_rep[d] = 0;
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_halt[d] = 0; m_halted[d] = 0;
      m_rep[d] = 0; m_ill[d] = 0; m_cnt[d] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      m_step(0, int'(a_op), a_zero, a_start, a_ack);
      m_step(1, int'(b_op), b_zero, b_start, b_ack);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    #3;
    if (ctl_a !== 11'd0) begin
      n_bad++; $display("FAIL reset ctl_a got=%b want=0", ctl_a);
    end
    n_cmp++;
    if (regs_a !== 19'd0) begin
      n_bad++; $display("FAIL reset regs_a got=%h want=0", regs_a);
    end
    n_cmp++;
    if (regs_b !== 6'd0) begin
      n_bad++; $display("FAIL reset regs_b got=%h want=0", regs_b);
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start_ldi();
    @(negedge clk);
    a_op = 5'd3; a_start = 1'b1;
    #1;
    if (ctl_a !== 11'd0) begin
      n_bad++; $display("FAIL idle_ctl got=%b want=0", ctl_a);
    end
    n_cmp++;
    tick();
    @(negedge clk);
    a_start = 1'b0;
    #1;
    if (ctl_a !== exp_ctl(0, 3, a_zero)) begin
      n_bad++;
      $display("FAIL ldi_ctl got=%b want=%b", ctl_a, exp_ctl(0, 3, a_zero));
    end
    n_cmp++;
    tick();
    if (ifa.CycleCount !== 16'd1) begin
      n_bad++; $display("FAIL ldi_cnt got=%0d want=1", ifa.CycleCount);
    end
    n_cmp++;
    @(negedge clk);
    a_op = 5'd0;
    tick();
    @(negedge clk);
    a_ack = 1'b1;
    tick();
    @(negedge clk);
    a_ack = 1'b0;
  endtask

  task automatic test_program();
    int prog[5] = '{3, 4, 7, 1, 0};
    @(negedge clk);
    a_start = 1'b1;
    tick();
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      a_op = (i < 5) ? 5'(prog[i]) : 5'($urandom_range(0, 31));
      a_zero = 1'($urandom);
      a_ack = (i == 7);
      #1;
      if (ctl_a !== exp_ctl(0, int'(a_op), a_zero)) begin
        n_bad++;
        $display("FAIL prog_ctl i=%0d got=%b want=%b", i, ctl_a,
                 exp_ctl(0, int'(a_op), a_zero));
      end
      n_cmp++;
      tick();
      if (regs_a !== exp_ra()) begin
        n_bad++;
        $display("FAIL prog_regs i=%0d got=%h want=%h", i, regs_a, exp_ra());
      end
      n_cmp++;
      if (i == 4 && regs_a !== {3'b110, 16'd4}) begin
        n_bad++; $display("FAIL hlt_regs got=%h want=%h", regs_a, {3'b110, 16'd4});
      end
      if (i == 4) n_cmp++;
    end
    if (ifa.ReportReq !== 1'b0 || ifa.Halted !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_clear got=%b%b want=00", ifa.Halted, ifa.ReportReq);
    end
    n_cmp++;
    @(negedge clk);
    a_ack = 1'b0;
  endtask

  task automatic test_branch();
    int ops[9] = '{16, 16, 17, 17, 18, 18, 19, 0, 0};
    bit zs[9] = '{1, 0, 1, 0, 0, 1, 0, 0, 0};
    @(negedge clk);
    a_start = 1'b1;
    tick();
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      a_op = 5'(ops[i]); a_zero = zs[i]; a_ack = (i == 8);
      #1;
      if (ctl_a !== exp_ctl(0, ops[i], zs[i])) begin
        n_bad++;
        $display("FAIL branch op=%0d z=%0d got=%b want=%b", ops[i], zs[i],
                 ctl_a, exp_ctl(0, ops[i], zs[i]));
      end
      n_cmp++;
      tick();
    end
    @(negedge clk);
    a_ack = 1'b0;
  endtask

  task automatic test_illegal();
    @(negedge clk);
    a_start = 1'b1;
    tick();
    @(negedge clk);
    a_start = 1'b0; a_op = 5'd31;
    #1;
    if (ifa.WrPC !== 1'b0) begin
      n_bad++; $display("FAIL trap_wrpc got=%b want=0", ifa.WrPC);
    end
    n_cmp++;
    tick();
    if ({ifa.Illegal, ifa.Halted} !== 2'b11) begin
      n_bad++;
      $display("FAIL trap_flags got=%b%b want=11", ifa.Illegal, ifa.Halted);
    end
    n_cmp++;
    @(negedge clk);
    a_ack = 1'b1;
    tick();
    @(negedge clk);
    a_ack = 1'b0; b_start = 1'b1;
    tick();
    @(negedge clk);
    b_start = 1'b0; b_op = 5'd8;
    #1;
    if (ctl_b !== exp_ctl(1, 8, b_zero)) begin
      n_bad++;
      $display("FAIL noext_ctl got=%b want=%b", ctl_b, exp_ctl(1, 8, b_zero));
    end
    n_cmp++;
    tick();
    @(negedge clk);
    b_op = 5'd31;
    #1;
    if (ifb.WrPC !== 1'b1) begin
      n_bad++; $display("FAIL nop_wrpc got=%b want=1", ifb.WrPC);
    end
    n_cmp++;
    tick();
    if ({ifb.Illegal, ifb.Halted} !== 2'b10 || regs_b !== exp_rb()) begin
      n_bad++;
      $display("FAIL nop_regs got=%h want=%h", regs_b, exp_rb());
    end
    n_cmp++;
    @(negedge clk);
    b_op = 5'd0;
    tick();
    @(negedge clk);
    b_ack = 1'b1;
    tick();
    @(negedge clk);
    b_ack = 1'b0;
  endtask

  task automatic test_saturate();
    @(negedge clk);
    b_start = 1'b1;
    tick();
    @(negedge clk);
    b_start = 1'b0; b_op = 5'd19;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (regs_b !== exp_rb()) begin
        n_bad++; $display("FAIL sat_regs i=%0d got=%h want=%h", i, regs_b, exp_rb());
      end
      n_cmp++;
    end
    if (ifb.CycleCount !== 3'd7) begin
      n_bad++; $display("FAIL sat_cnt got=%0d want=7", ifb.CycleCount);
    end
    n_cmp++;
    @(negedge clk);
    b_op = 5'd0;
    tick();
    @(negedge clk);
    b_ack = 1'b1;
    tick();
    @(negedge clk);
    b_ack = 1'b0; b_start = 1'b1;
    tick();
    if (ifb.CycleCount !== 3'd0) begin
      n_bad++; $display("FAIL restart_cnt got=%0d want=0", ifb.CycleCount);
    end
    n_cmp++;
    @(negedge clk);
    b_start = 1'b0;
    tick();
    @(negedge clk);
    b_ack = 1'b1;
    tick();
    @(negedge clk);
    b_ack = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a_op = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(1, 19))
                                         : 5'($urandom_range(0, 31));
      b_op = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(1, 19))
                                         : 5'($urandom_range(0, 31));
      a_zero = 1'($urandom); b_zero = 1'($urandom);
      a_start = 1'($urandom); b_start = 1'($urandom);
      a_ack = 1'($urandom); b_ack = 1'($urandom);
      #1;
      if (ctl_a !== exp_ctl(0, int'(a_op), a_zero)) begin
        n_bad++;
        $display("FAIL rnd_ctl_a i=%0d op=%0d got=%b want=%b", i, a_op,
                 ctl_a, exp_ctl(0, int'(a_op), a_zero));
      end
      n_cmp++;
      if (ctl_b !== exp_ctl(1, int'(b_op), b_zero)) begin
        n_bad++;
        $display("FAIL rnd_ctl_b i=%0d op=%0d got=%b want=%b", i, b_op,
                 ctl_b, exp_ctl(1, int'(b_op), b_zero));
      end
      n_cmp++;
      tick();
      if (regs_a !== exp_ra()) begin
        n_bad++; $display("FAIL rnd_regs_a i=%0d got=%h want=%h", i, regs_a, exp_ra());
      end
      n_cmp++;
      if (regs_b !== exp_rb()) begin
        n_bad++; $display("FAIL rnd_regs_b i=%0d got=%h want=%h", i, regs_b, exp_rb());
      end
      n_cmp++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a_op = 5'd19; a_ack = 1'b1; a_start = 1'b0;
    b_start = 1'b0; b_ack = 1'b0;
    tick();
    @(negedge clk);
    a_ack = 1'b0; a_start = 1'b1;
    tick();
    @(negedge clk);
    a_start = 1'b0; a_op = 5'd3;
    #1;
    if (!m_run[0] || ctl_a !== exp_ctl(0, 3, a_zero)) begin
      n_bad++; $display("FAIL pre_rst got=%b want=%b", ctl_a, exp_ctl(0, 3, a_zero));
    end
    n_cmp++;
    #1;
    rst_n = 1'b0;
    m_reset();
    #1;
    if (ctl_a !== 11'd0 || regs_a !== 19'd0) begin
      n_bad++; $display("FAIL async_rst got=%b/%h want=0/0", ctl_a, regs_a);
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    #1;
    if (ctl_a !== 11'd0 || regs_a !== 19'd0) begin
      n_bad++; $display("FAIL no_resume got=%b/%h want=0/0", ctl_a, regs_a);
    end
    n_cmp++;
  endtask

  initial begin
    int codes[5] = '{1, 0, 2, 3, 4};
    tbl[0] = mk(0, 0, 2'd0, 0, 0, 3'd0, 0, 0);
    tbl[1] = mk(1, 0, 2'd0, 0, 0, 3'd0, 1, 0);
    tbl[2] = mk(1, 0, 2'd0, 0, 1, 3'd0, 0, 1);
    tbl[3] = mk(1, 0, 2'd1, 0, 1, 3'd0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tbl[4 + 2 * k] = mk(1, 0, 2'd2, 0, 1, 3'(codes[k]), 0, 1);
      tbl[5 + 2 * k] = mk(1, 0, 2'd2, 1, 1, 3'(codes[k]), 0, 0);
    end
    tbl[14] = mk(1, 0, 2'd2, 1, 1, 3'd5, 0, 0);
    tbl[15] = mk(1, 0, 2'd2, 1, 1, 3'd6, 0, 0);
    for (int k = 16; k < 20; k++) tbl[k] = mk(1, 0, 2'd0, 0, 0, 3'd0, 0, 0);

    #1;
    test_reset();
    test_start_ldi();
    test_program();
    test_branch();
    test_illegal();
    test_saturate();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
Sequenced control unit for the BIP accumulator processor; the next generation of the combinational instruction decoder. Decodes the 5-bit opcode into datapath controls and adds logic/shift/branch opcodes. Adds a run/halt state machine gated by a Start input, a halt-report handshake toward the UART reporter, an illegal-opcode trap and a saturating executed-cycle counter. Sits between program memory (OpCode) and the PC/accumulator/ALU/data-memory datapath.

Parameters:
OPCODE_W, 5, opcode width; values below 5 are unsupported; upper bits above bit 4 must be 0 for a legal opcode.
CNT_W, 16, width of CycleCount.
EXT_EN, 1, 1 = extended opcodes 01000-10011 legal; 0 = only 00000-00111 legal.
ILLEGAL_HALT, 1, 1 = illegal opcode traps to HALT; 0 = illegal opcode executes as NOP.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
OpCode  in  OPCODE_W  current instruction opcode.
Zero  in  1  accumulator == 0 flag from datapath.
Start  in  1  begin execution; sampled in IDLE only.
ReportAck  in  1  UART reporter finished sending halt report.
WrPC  out  1  PC update enable.
PcLoad  out  1  1 = PC loads immediate (branch taken), 0 = PC+1.
SelA  out  2  accumulator mux: 0 = DM data, 1 = immediate, 2 = ALU.
SelB  out  1  ALU operand B: 0 = DM data, 1 = immediate.
WrAcc  out  1  accumulator write enable.
AluOp  out  3  0 SUB, 1 ADD, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL.
WrRam  out  1  data-memory write.
RdRam  out  1  data-memory read.
Halted  out  1  registered; 1 in HALT state.
ReportReq  out  1  registered; request halt report, held until ReportAck.
Illegal  out  1  registered, sticky; an illegal opcode was fetched.
CycleCount  out  CNT_W  registered; instructions executed in RUN.

Behaviour:
- States: IDLE, RUN, HALT. Reset (reset=0): state IDLE, Halted=0, ReportReq=0, Illegal=0, CycleCount=0; all combinational controls are 0 while reset is low.
- Controls are combinational from OpCode, gated by state: in IDLE and HALT, WrPC=PcLoad=WrAcc=WrRam=RdRam=0, SelA=0, SelB=0, AluOp=0. No latches: every output is assigned in every path.
- RUN decode (WrPC=1 unless stated):
  - HLT 00000: WrPC=0.
  - STO 00001: WrRam=1.
  - LD 00010: RdRam=1, WrAcc=1, SelA=0.
  - LDI 00011: WrAcc=1, SelA=1.
  - ADD/ADDI 00100/00101: WrAcc=1, SelA=2, AluOp=1; SelB=0 with RdRam=1 / SelB=1.
  - SUB/SUBI 00110/00111: as ADD/ADDI with AluOp=0.
  - AND/ANDI 01000/01001, OR/ORI 01010/01011, XOR/XORI 01100/01101: as ADD/ADDI with AluOp 2/3/4.
  - SLL 01110, SRL 01111: WrAcc=1, SelA=2, SelB=1, AluOp 5/6.
  - BEQ 10000: PcLoad=Zero. BNE 10001: PcLoad=~Zero. JMP 10010: PcLoad=1.
  - NOP 10011: WrPC only.
  - Illegal (opcode > 10011, upper bits nonzero, or extended opcode with EXT_EN=0): ILLEGAL_HALT=1 acts as HLT (WrPC=0); ILLEGAL_HALT=0 acts as NOP.
- Transitions (on clk):
  - IDLE -> RUN on Start=1; CycleCount cleared to 0 and Illegal cleared on the same edge.
  - RUN -> HALT when OpCode is HLT, or illegal with ILLEGAL_HALT=1. Illegal<=1 on any illegal opcode in RUN, in either mode.
  - HALT -> IDLE on ReportAck=1.
- CycleCount increments by 1 on every RUN cycle in which WrPC=1, saturates at all-ones and holds; HLT/trap cycles do not count.
- Halted<=1 and ReportReq<=1 on entry to HALT. ReportReq<=0 on the ReportAck edge; Halted<=0 on leaving HALT. Halted is visible the cycle after the HLT fetch.
- ReportAck outside HALT is ignored. Start outside IDLE is ignored. Start and ReportAck both high in HALT: go to IDLE only; Start is acted on in a later cycle.
- Reset asserted mid-run returns immediately to IDLE with all outputs at reset values; Illegal and CycleCount are lost.

Test Plan:
- Reset, then Start pulse with OpCode=00011 -> cycle 0 in IDLE: all controls 0; after Start edge, WrPC=1, WrAcc=1, SelA=1; CycleCount=1 after the next edge.
- Program LDI, ADD, SUBI, STO, HLT, one per cycle -> exact control vectors per opcode. HLT: WrPC=0, Halted=1 and ReportReq=1 next cycle, CycleCount=4. ReportAck high 3 cycles later -> ReportReq=0, state IDLE.
- BEQ with Zero=1 -> PcLoad=1. BEQ with Zero=0 -> PcLoad=0, WrPC=1. BNE is the inverse. JMP gives PcLoad=1 regardless of Zero.
- OpCode=11111 with ILLEGAL_HALT=1 -> WrPC=0, Illegal=1, Halted=1. With ILLEGAL_HALT=0 -> WrPC=1, Illegal=1, state stays RUN. With EXT_EN=0, opcode 01000 is treated as illegal.
- CNT_W=3, 10 NOPs -> CycleCount saturates at 7. A new Start from IDLE clears it to 0.
- reset asserted asynchronously between clock edges during RUN -> all outputs 0 immediately; Start remains required to resume.
